// File: rtl/usb_crc_engine_pkg.sv
// usb_pkg: USB CRC polynomials, good-packet residuals and the state type
// shared by the serial CRC engine and its datapath helpers.
package usb_pkg;

    localparam logic [4:0]  USB_CRC5_POLY  = 5'h05;
    localparam logic [4:0]  USB_CRC5_RES   = 5'h0C;
    localparam logic [15:0] USB_CRC16_POLY = 16'h8005;
    localparam logic [15:0] USB_CRC16_RES  = 16'h800D;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        APPEND,
        DONE
    } crc_state_e;

endpackage

// File: rtl/usb_crc_engine_if.sv
// Bit-level handshake between a packet RX/TX path and usb_crc_engine.
// Optional macro USB_CRC_ERR_LATCH_EN adds the eop input and the crc_err output.
interface usb_crc_engine_if #(
    parameter int WIDTH = 16
);

    logic             clken;
    logic             init;
    logic             d;
    logic             start_append;
    logic             out;
    logic             out_valid;
    logic             append_done;
    logic             crc_ok;
    logic [WIDTH-1:0] crc;
`ifdef USB_CRC_ERR_LATCH_EN
    logic             eop;
    logic             crc_err;
`endif

    modport master (
`ifdef USB_CRC_ERR_LATCH_EN
        output eop,
        input  crc_err,
`endif
        output clken,
        output init,
        output d,
        output start_append,
        input  out,
        input  out_valid,
        input  append_done,
        input  crc_ok,
        input  crc
    );

    modport slave (
`ifdef USB_CRC_ERR_LATCH_EN
        input  eop,
        output crc_err,
`endif
        input  clken,
        input  init,
        input  d,
        input  start_append,
        output out,
        output out_valid,
        output append_done,
        output crc_ok,
        output crc
    );

endinterface

// File: rtl/usb_crc_engine_lfsr_step.sv
// usb_lfsr_step: one serial step of an MSB-aligned CRC LFSR.
// With dump set the register simply shifts left (used to emit the CRC);
// otherwise the incoming bit is folded in through the generator polynomial.
module usb_lfsr_step #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h8005
) (
    input  logic [WIDTH-1:0] r,
    input  logic             d,
    input  logic             dump,
    output logic [WIDTH-1:0] r_next
);

    logic [WIDTH-1:0] shifted;
    logic             fb;

    // Shift-and-xor next value; the feedback bit is the outgoing MSB xor data.
    always_comb begin
        shifted = {r[WIDTH-2:0], 1'b0};
        fb      = r[WIDTH-1] ^ d;
        if (dump) begin
            r_next = shifted;
        end else if (fb) begin
            r_next = shifted ^ POLY;
        end else begin
            r_next = shifted;
        end
    end

endmodule

// File: rtl/usb_crc_engine.sv
// usb_crc_engine: serial USB CRC5/CRC16 checker/generator, one bit per clken.
// Receive: absorbs bits and flags the good-packet residual on crc_ok.
// Transmit: on start_append shifts out the inverted CRC, MSB first.
// Optional macro USB_CRC_ERR_LATCH_EN adds an eop-sampled crc_err latch.
module usb_crc_engine
    import usb_pkg::*;
#(
    parameter int          WIDTH    = 16,
    parameter logic [15:0] POLY     = USB_CRC16_POLY,
    parameter logic [15:0] INIT     = 16'hFFFF,
    parameter logic [15:0] RESIDUAL = USB_CRC16_RES
) (
    input  logic            clk,
    input  logic            rst_n,
    usb_crc_engine_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] POLY_W   = POLY[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INIT_W   = INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RES_W    = RESIDUAL[WIDTH-1:0];
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    crc_state_e       state;
    crc_state_e       state_next;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] r_step;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             dump;

    assign dump = (state == APPEND);

    usb_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY_W)
    ) u_lfsr_step (
        .r      (r),
        .d      (bus.d),
        .dump   (dump),
        .r_next (r_step)
    );

    // State, LFSR and bit counter registers; reset lands in IDLE with r=INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r     <= INIT_W;
            cnt   <= '0;
        end else begin
            state <= state_next;
            r     <= r_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: init overrides everything, the append request steals its
    // bit-time (no data absorbed) and DONE reloads INIT for the next packet.
    always_comb begin
        state_next = state;
        r_next     = r;
        cnt_next   = cnt;
        if (bus.init) begin
            state_next = IDLE;
            r_next     = INIT_W;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (bus.clken) begin
                        if (bus.start_append) begin
                            state_next = APPEND;
                            cnt_next   = CNT_LAST;
                        end else begin
                            state_next = RUN;
                            r_next     = r_step;
                        end
                    end
                end
                APPEND: begin
                    if (bus.clken) begin
                        r_next = r_step;
                        if (cnt == '0) begin
                            state_next = DONE;
                        end else begin
                            cnt_next = cnt - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                    r_next     = INIT_W;
                    cnt_next   = '0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of the registered state and LFSR.
    always_comb begin
        bus.out         = ~r[WIDTH-1];
        bus.out_valid   = (state == APPEND);
        bus.append_done = (state == DONE);
        bus.crc_ok      = (r == RES_W);
        bus.crc         = r;
    end

`ifdef USB_CRC_ERR_LATCH_EN
    logic crc_err_q;

    // Sticky packet verdict captured at end-of-packet, cleared by init.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_err_q <= 1'b0;
        end else if (bus.init) begin
            crc_err_q <= 1'b0;
        end else if (bus.eop) begin
            crc_err_q <= (r != RES_W);
        end
    end

    assign bus.crc_err = crc_err_q;
`endif

endmodule
